fp_mul_arbiter: RTL and testbench

Shares one pipelined FP16 multiplier (fp_mul built with PIPLINE) among N_REQ requesters. Round-robin arbitration with valid/ready request ports, an in-flight tag pipeline that matches the multiplier latency, and a credit-guarded result FIFO with a valid/ready response port tagged by requester ID. Sits between PE-row operand feeders and the shared multiplier instance in the MAC cluster.

---
 rtl/fp_mul_arbiter_pkg.sv | 24 ++
 rtl/fp_mul_arbiter_if.sv | 35 +++
 rtl/fp_res_fifo.sv | 69 ++++++
 rtl/fp_mul_arbiter.sv | 126 ++++++++++++
 tb/tb_fp_mul_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_mul_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_arbiter_pkg
// Brief    : Shared FP16 constants and helpers for the shared-multiplier arbiter
// Revision : 1.0 - initial release
// ============================================================================
package fp_mul_arbiter_pkg;

    localparam int          FP16_W    = 16;
    localparam logic [15:0] FP16_ONE  = 16'h3C00;
    localparam logic [15:0] FP16_TWO  = 16'h4000;
    localparam logic [15:0] FP16_ZERO = 16'h0000;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_mul_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_arbiter_if
// Brief    : Request (valid/ready, packed FP16 operands) and tagged response bus
// Revision : 1.0 - initial release
// ============================================================================
interface fp_mul_arbiter_if
    import fp_mul_arbiter_pkg::*;
#(
    parameter int N_REQ = 4
) ();

    localparam int ID_W = clog2(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*FP16_W-1:0] req_a;
    logic [N_REQ*FP16_W-1:0] req_b;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [FP16_W-1:0]       rsp_data;
    logic [ID_W-1:0]         rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );

endinterface
`default_nettype wire

// File: rtl/fp_res_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fp_res_fifo
// Brief    : Synchronous FIFO with occupancy count; push+pop legal at full/empty
// Revision : 1.0 - initial release
// ============================================================================
module fp_res_fifo
    import fp_mul_arbiter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic [clog2(DEPTH+1)-1:0]    count,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_do_pop  = pop & ~empty;
    // A push at full is accepted when the head leaves in the same cycle.
    assign w_do_push = push & (~full | w_do_pop);
    assign head_data = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_arbiter
// Brief    : Round-robin share of one pipelined FP16 multiplier, credit-guarded
//            tagged result FIFO
// Revision : 1.0 - initial release
// ============================================================================
module fp_mul_arbiter
    import fp_mul_arbiter_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int MUL_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fp_mul_arbiter_if.slave      bus,
    output logic [FP16_W-1:0]    mul_a,
    output logic [FP16_W-1:0]    mul_b,
    input  logic [FP16_W-1:0]    mul_c,
    output logic                 busy
);

    localparam int ID_W  = clog2(N_REQ);
    localparam int CNT_W = clog2(FIFO_DEPTH + 1);

    logic [ID_W-1:0]        r_rr_ptr;
    logic [MUL_LAT-1:0]     r_tag_v;
    logic [ID_W-1:0]        r_tag_id [MUL_LAT];

    logic [ID_W-1:0]        w_winner;
    logic [ID_W-1:0]        w_scan_idx;
    logic                   w_found;
    logic                   w_credit_ok;
    logic                   w_issue;
    logic [31:0]            w_inflight_cnt;
    logic [31:0]            w_occupancy;
    logic                   w_push;
    logic                   w_pop;
    logic [CNT_W-1:0]       w_fifo_cnt;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [FP16_W+ID_W-1:0] w_head;

    // Credit counts only registered occupancy; a same-cycle pop is not credited.
    always_comb begin
        w_inflight_cnt = '0;
        for (int s = 0; s < MUL_LAT; s++) begin
            w_inflight_cnt = w_inflight_cnt + 32'(r_tag_v[s]);
        end
        w_occupancy = w_inflight_cnt + 32'(w_fifo_cnt);
        w_credit_ok = (w_occupancy < 32'(FIFO_DEPTH));
    end

    always_comb begin
        w_found    = 1'b0;
        w_winner   = r_rr_ptr;
        w_scan_idx = r_rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            w_scan_idx = r_rr_ptr + ID_W'(k);
            if (!w_found && bus.req_valid[w_scan_idx]) begin
                w_found  = 1'b1;
                w_winner = w_scan_idx;
            end
        end
    end

    // rst_n gates issue so nothing is granted while reset is held.
    assign w_issue = rst_n & w_credit_ok & w_found;

    always_comb begin
        bus.req_ready = '0;
        mul_a         = FP16_ZERO;
        mul_b         = FP16_ZERO;
        if (w_issue) begin
            bus.req_ready[w_winner] = 1'b1;
            mul_a = bus.req_a[int'(w_winner)*FP16_W +: FP16_W];
            mul_b = bus.req_b[int'(w_winner)*FP16_W +: FP16_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_tag_v  <= '0;
            for (int s = 0; s < MUL_LAT; s++) begin
                r_tag_id[s] <= '0;
            end
        end else begin
            if (w_issue) begin
                r_rr_ptr <= w_winner + ID_W'(1);
            end
            r_tag_v[0]  <= w_issue;
            r_tag_id[0] <= w_winner;
            for (int s = 1; s < MUL_LAT; s++) begin
                r_tag_v[s]  <= r_tag_v[s-1];
                r_tag_id[s] <= r_tag_id[s-1];
            end
        end
    end

    assign w_push = r_tag_v[MUL_LAT-1];
    assign w_pop  = bus.rsp_valid & bus.rsp_ready;

    fp_res_fifo #(
        .WIDTH (FP16_W + ID_W),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data ({mul_c, r_tag_id[MUL_LAT-1]}),
        .pop       (w_pop),
        .head_data (w_head),
        .count     (w_fifo_cnt),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    assign bus.rsp_valid = ~w_fifo_empty;
    assign bus.rsp_data  = w_head[ID_W +: FP16_W];
    assign bus.rsp_id    = w_head[ID_W-1:0];
    assign busy          = (w_inflight_cnt != '0) | ~w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mul_arbiter
// Brief    : Directed self-checking bench with a behavioural 1-cycle FP16 multiplier
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fp_mul_arbiter;
    import fp_mul_arbiter_pkg::*;

    localparam int N_REQ      = 4;
    localparam int MUL_LAT    = 1;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mul_a, mul_b, mul_c;
    logic        busy;

    logic        f_push, f_pop, f_full, f_empty;
    logic [15:0] f_data, f_head;
    logic [2:0]  f_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        overflow_seen = 1'b0;
    logic [15:0] q_data [$];
    logic [1:0]  q_id   [$];

    always #5 clk = ~clk;

    fp_mul_arbiter_if #(.N_REQ(N_REQ)) bus ();

    fp_mul_arbiter #(
        .N_REQ      (N_REQ),
        .MUL_LAT    (MUL_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .mul_a (mul_a),
        .mul_b (mul_b),
        .mul_c (mul_c),
        .busy  (busy)
    );

    fp_res_fifo #(.WIDTH(16), .DEPTH(4)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (f_push),
        .push_data (f_data),
        .pop       (f_pop),
        .head_data (f_head),
        .count     (f_count),
        .full      (f_full),
        .empty     (f_empty)
    );

    // Truncating FP16 multiply, normals and zeros only.
    function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        int          e;
        logic [21:0] m;
        s = a[15] ^ b[15];
        if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {s, 15'd0};
        e = int'(a[14:10]) + int'(b[14:10]) - 15;
        m = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
        if (m[21]) begin
            m = m >> 1;
            e = e + 1;
        end
        return {s, e[4:0], m[19:10]};
    endfunction

    always @(posedge clk) mul_c <= fp16_mul(mul_a, mul_b);

    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            q_data.push_back(bus.rsp_data);
            q_id.push_back(bus.rsp_id);
        end
        if (dut.w_push && dut.w_fifo_full && !dut.w_pop) overflow_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rsp_valid) check(tag, 32'(bus.rsp_valid), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        bus.req_a[i*16 +: 16] = a;
        bus.req_b[i*16 +: 16] = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int           accepts;
        logic         stale;
        logic [15:0]  exp_d;
        logic [15:0]  exp_f [4];

        rst_n         = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_a     = {4{FP16_TWO}};
        bus.req_b     = {4{FP16_ONE}};
        bus.rsp_ready = 1'b0;
        f_push = 1'b0; f_pop = 1'b0; f_data = 16'h0;
        repeat (2) step();

        // Reset state, with all requesters asserting valid
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_busy",      32'(busy),          32'h0);
        check("rst_rsp_data",  32'(bus.rsp_data),  32'h0);
        check("rst_rsp_id",    32'(bus.rsp_id),    32'h0);
        check("rst_mul_a",     32'(mul_a),         32'h0);
        step();
        rst_n = 1'b1;
        bus.req_valid = 4'b0000;
        step();

        // Single request from requester 1: 1.0 * 2.0
        bus.req_valid = 4'b0010;
        set_op(1, 16'h3C00, 16'h4000);
        @(negedge clk);
        check("single_ready", 32'(bus.req_ready), 32'h2);
        check("single_mul_a", 32'(mul_a), 32'h3C00);
        check("single_mul_b", 32'(mul_b), 32'h4000);
        step();
        bus.req_valid = 4'b0000;
        wait_rsp("single_timeout");
        check("single_data", 32'(bus.rsp_data), 32'h4000);
        check("single_id",   32'(bus.rsp_id),   32'h1);
        step();
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        wait_idle("single_idle");

        // Round robin from a fresh pointer with all requesters streaming
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        q_data.delete(); q_id.delete();
        for (int i = 0; i < 4; i++) set_op(i, 16'h4000 + 16'(i * 256), FP16_ONE);
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rr_grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
            step();
        end
        bus.req_valid = 4'b0000;
        wait_idle("rr_idle");
        check("rr_count", 32'(q_id.size()), 32'd5);
        for (int k = 0; k < 5 && k < q_id.size(); k++) begin
            check("rr_rsp_id",   32'(q_id[k]),   32'(k % 4));
            check("rr_rsp_data", 32'(q_data[k]), 32'(16'h4000 + 16'((k % 4) * 256)));
        end

        // Backpressure: requester 0 streams with the consumer stalled
        step();
        bus.rsp_ready = 1'b0;
        q_data.delete(); q_id.delete();
        exp_d = 16'h4000;
        set_op(0, exp_d, FP16_ONE);
        bus.req_valid = 4'b0001;
        accepts = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            stale = bus.req_ready[0];
            step();
            if (stale) begin
                accepts++;
                exp_d = exp_d + 16'h0100;
                set_op(0, exp_d, FP16_ONE);
            end
        end
        @(negedge clk);
        check("bp_accepts",  32'(accepts),         32'd4);
        check("bp_stall",    32'(bus.req_ready),   32'h0);
        check("bp_fifo_cnt", 32'(dut.w_fifo_cnt),  32'd4);
        step();
        bus.req_valid = 4'b0000;
        bus.rsp_ready = 1'b1;
        repeat (6) step();
        check("bp_drained", 32'(q_data.size()), 32'd4);
        for (int k = 0; k < 4 && k < q_data.size(); k++) begin
            check("bp_order", 32'(q_data[k]), 32'(16'h4000 + 16'(k * 256)));
        end
        bus.req_valid = 4'b0001;
        @(negedge clk);
        check("bp_resume", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = 4'b0000;
        wait_idle("bp_idle");

        // Zero operand from requester 3
        step();
        bus.rsp_ready = 1'b0;
        set_op(3, FP16_ZERO, 16'h4200);
        bus.req_valid = 4'b1000;
        @(negedge clk);
        check("zero_ready", 32'(bus.req_ready), 32'h8);
        step();
        bus.req_valid = 4'b0000;
        wait_rsp("zero_timeout");
        check("zero_data", 32'(bus.rsp_data), 32'h0000);
        check("zero_id",   32'(bus.rsp_id),   32'h3);
        step();
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;

        // Reset with one tag in flight and two results queued
        set_op(0, 16'h4000, FP16_ONE);
        bus.req_valid = 4'b0001;
        repeat (3) step();
        check("mid_fifo_cnt", 32'(dut.w_fifo_cnt), 32'd2);
        check("mid_inflight", 32'(dut.r_tag_v),    32'd1);
        bus.req_valid = 4'b1111;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("mid_rst_busy",      32'(busy),          32'h0);
        check("mid_rst_mul_a",     32'(mul_a),         32'h0);
        check("mid_rst_rsp_data",  32'(bus.rsp_data),  32'h0);
        check("mid_rst_rsp_id",    32'(bus.rsp_id),    32'h0);
        step();
        bus.req_valid = 4'b0000;
        rst_n = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            stale = stale | bus.rsp_valid | busy;
        end
        check("post_rst_stale", 32'(stale), 32'h0);
        step();
        bus.req_valid = 4'b1111;
        @(negedge clk);
        check("post_rst_rr", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = 4'b0000;
        bus.rsp_ready = 1'b1;
        wait_idle("post_rst_idle");

        // Result FIFO: push and pop together while full
        exp_f[0] = 16'h2222; exp_f[1] = 16'h3333; exp_f[2] = 16'h4444; exp_f[3] = 16'hAAAA;
        step();
        for (int k = 1; k <= 4; k++) begin
            f_push = 1'b1;
            f_data = 16'(k * 16'h1111);
            step();
        end
        f_push = 1'b0;
        @(negedge clk);
        check("fifo_full_cnt",  32'(f_count), 32'd4);
        check("fifo_full_flag", 32'(f_full),  32'd1);
        check("fifo_head0",     32'(f_head),  32'h1111);
        step();
        f_push = 1'b1; f_pop = 1'b1; f_data = 16'hAAAA;
        step();
        f_push = 1'b0; f_pop = 1'b0;
        @(negedge clk);
        check("fifo_pp_cnt",  32'(f_count), 32'd4);
        check("fifo_pp_head", 32'(f_head),  32'h2222);
        step();
        f_pop = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("fifo_drain", 32'(f_head), 32'(exp_f[k]));
            step();
        end
        f_pop = 1'b0;
        @(negedge clk);
        check("fifo_empty", 32'(f_empty), 32'd1);

        check("no_overflow", 32'(overflow_seen), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
